rom_arbiter: RTL

Parametrised N-channel arbiter for the shared external ROM/SDRAM port, successor to the two-channel PRG/CHR ROM arbiter. It sits between the mapper-side fetch ports (PRG, CHR and any added expansion/audio ports) and the single downstream memory port. It adds:
- round-robin or fixed-priority selection
- per-channel base-offset relocation
- per-channel enable masking
- grant visibility

---
 rtl/rom_arbiter_pkg.sv | 19 +
 rtl/rom_arbiter_rr_pick.sv | 32 +++
 rtl/rom_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared types and helpers for the ROM port arbiter.
package rom_arbiter_pkg;

  // Transaction phases of the downstream port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Width of the round-robin pointer: max(1, clog2(n)).
  function automatic int ptr_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from ptr, or fixed lowest-index priority.
module rr_pick
  import rom_arbiter_pkg::*;
#(
  parameter int N          = 2,
  parameter int FIXED_PRIO = 0,
  parameter int PW         = ptr_width(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] win_idx,
  output logic          win_valid
);

  // Scan N candidates starting at ptr (or 0 in fixed mode), wrapping; first eligible wins.
  always_comb begin
    int cand;
    // NOTE: every output gets a default first so no path through the block infers a latch.
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (FIXED_PRIO != 0) ? k : int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!win_valid && elig[cand]) begin
        win_valid = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// N-channel arbiter for the shared external ROM/SDRAM port with base relocation,
// enable masking and registered grant visibility.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int N          = 2,
  parameter int AW         = 21,
  parameter int MAW        = 22,
  parameter int DW         = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     ch_en,
  input  logic [N-1:0]     ch_req,
  input  logic [N*AW-1:0]  ch_addr,
  input  logic [N*MAW-1:0] ch_base,
  output logic [N-1:0]     ch_ack,
  output logic [DW-1:0]    ch_rdata,
  output logic [MAW-1:0]   m_addr,
  output logic             m_req,
  input  logic             m_ack,
  input  logic [DW-1:0]    m_rdata,
  output logic [N-1:0]     grant,
  output logic             busy
);

  localparam int PW = ptr_width(N);

  arb_state_e     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           m_req_q, m_req_d;
  logic [MAW-1:0] m_addr_q, m_addr_d;
  logic [N-1:0]   ch_ack_q, ch_ack_d;
  logic [DW-1:0]  ch_rdata_q, ch_rdata_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   elig;
  logic [PW-1:0]  win_idx;
  logic           win_valid;
  logic [AW-1:0]  win_addr;
  logic [MAW-1:0] win_base;
  logic [MAW-1:0] win_addr_ext;
  logic [MAW-1:0] reloc_addr;
  logic [N-1:0]   win_onehot;
  logic [PW-1:0]  next_ptr;

  assign elig = ch_req & ch_en;

  rr_pick #(
    .N         (N),
    .FIXED_PRIO(FIXED_PRIO),
    .PW        (PW)
  ) u_pick (
    .elig     (elig),
    .ptr      (ptr_q),
    .win_idx  (win_idx),
    .win_valid(win_valid)
  );

  // Relocate the winner's address by its base (wraps modulo 2^MAW) and precompute its one-hot and next ptr.
  always_comb begin
    win_addr     = ch_addr[int'(win_idx)*AW +: AW];
    win_base     = ch_base[int'(win_idx)*MAW +: MAW];
    win_addr_ext = '0;
    win_addr_ext[AW-1:0] = win_addr;
    reloc_addr   = win_base + win_addr_ext;
    win_onehot   = '0;
    win_onehot[win_idx] = 1'b1;
    if (int'(win_idx) == N - 1) next_ptr = '0;
    else                        next_ptr = win_idx + PW'(1);
  end

  // Next-state and registered-output logic of the IDLE -> WAIT -> DONE transaction cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    m_req_d    = m_req_q;
    m_addr_d   = m_addr_q;
    ch_ack_d   = '0;
    ch_rdata_d = ch_rdata_q;
    grant_d    = grant_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          grant_d  = win_onehot;
          m_addr_d = reloc_addr;
          m_req_d  = 1'b1;
          state_d  = ST_WAIT;
          if (FIXED_PRIO == 0) ptr_d = next_ptr;
        end
      end
      ST_WAIT: begin
        // The owner's request/enable are not re-examined here: a started transaction always completes.
        if (m_ack) begin
          ch_rdata_d = m_rdata;
          ch_ack_d   = grant_q;
          m_req_d    = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        m_req_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any in-flight downstream request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      ch_ack_q   <= '0;
      ch_rdata_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates together from the pre-edge values.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      ch_ack_q   <= ch_ack_d;
      ch_rdata_q <= ch_rdata_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
    end
  end

  assign ch_ack   = ch_ack_q;
  assign ch_rdata = ch_rdata_q;
  assign m_addr   = m_addr_q;
  assign m_req    = m_req_q;
  assign grant    = grant_q;
  assign busy     = busy_q;

endmodule
